// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the ALU control stage and the multicycle ALU.
// The ALU control decoder drives the request side and the ALU returns result/flags.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       ALU_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, ALU_control, a, b,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, ALU_control, a, b,
    output result, zero, busy, done
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/add/sub, iterative shift-add multiply.
// Result and zero are held until the next completion, which is marked by a done pulse.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_multicycle_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] count_inc;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, datapath and completion logic
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    result_d  = result_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    op_res    = '0;
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    count_inc = count_q + CNT_W'(1);

    case (bus.ALU_control)
      OP_AND:  op_res = bus.a & bus.b;
      OP_OR:   op_res = bus.a | bus.b;
      OP_ADD:  op_res = bus.a + bus.b;
      OP_SUB:  op_res = bus.a - bus.b;
      default: op_res = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.ALU_control == OP_MUL) begin
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            count_d  = '0;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        // Fixed WIDTH iterations keep the stall length deterministic
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_inc;
        if (count_inc == CNT_W'(WIDTH)) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboarded bench for alu_multicycle: the driver queues expected completions,
// a negedge monitor matches every done pulse against the queue (value, zero, cycle).
module tb_alu_multicycle;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_UNK = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request at the current negedge; returns at the next negedge
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input bit push);
    exp_t e;
    bus.start       = 1'b1;
    bus.ALU_control = op;
    bus.a           = x;
    bus.b           = y;
    if (push) begin
      e.res = exp_res;
      e.z   = (exp_res == 32'h0);
      e.cyc = cyc + ((op == OP_MUL) ? 33 : 1);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Deassert start and scramble operands to show they are not re-sampled
  task automatic idle(input int n);
    bus.start       = 1'b0;
    bus.ALU_control = 3'($urandom_range(0, 7));
    bus.a           = $urandom;
    bus.b           = $urandom;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual result=%h expected no completion (cyc %0d)",
                 bus.result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (bus.result !== e.res || bus.zero !== e.z || cyc != e.cyc) begin
          errors++;
          $display("FAIL completion actual res=%h zero=%b cyc=%0d expected res=%h zero=%b cyc=%0d",
                   bus.result, bus.zero, cyc, e.res, e.z, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.ALU_control = 3'b000;
    bus.a           = '0;
    bus.b           = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_zero", 32'(bus.zero), 32'h1);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops back to back, busy must stay low
    issue(OP_AND, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_00F0, 1);
    chk("and_busy", 32'(bus.busy), 32'h0);
    issue(OP_OR,  32'h0000_00F0, 32'h0000_0FF0, 32'h0000_0FF0, 1);
    chk("or_busy", 32'(bus.busy), 32'h0);
    issue(OP_ADD, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_10E0, 1);
    chk("add_busy", 32'(bus.busy), 32'h0);
    issue(OP_SUB, 32'h0000_00F0, 32'h0000_0FF0, 32'hFFFF_F100, 1);
    chk("sub_busy", 32'(bus.busy), 32'h0);
    idle(3);

    // Wrap-around and zero flag
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1);
    issue(OP_SUB, 32'h5, 32'h5, 32'h0, 1);
    issue(OP_OR, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_0FF0, 1);
    issue(OP_UNK, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1);
    idle(3);

    // Asynchronous reset in the middle of a clock phase
    issue(OP_OR, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_0FF0, 1);
    idle(3);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_result", bus.result, 32'h0);
    chk("async_rst_zero", 32'(bus.zero), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Multiply 7*6 with busy length measurement
    issue(OP_MUL, 32'd7, 32'd6, 32'd42, 1);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 32'(n), 32'd32);
    idle(3);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    idle(40);
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 1);
    idle(40);

    // start while busy is ignored
    issue(OP_MUL, 32'd5, 32'd9, 32'd45, 1);
    idle(5);
    issue(OP_ADD, 32'd100, 32'd200, 32'd300, 0);
    idle(40);
    chk("ignored_add_result", bus.result, 32'd45);

    // New op accepted in the done cycle
    issue(OP_MUL, 32'd3, 32'h1111_1111, 32'h3333_3333, 1);
    idle(32);
    chk("b2b_done_cycle", 32'(bus.done), 32'h1);
    issue(OP_ADD, 32'd10, 32'd20, 32'd30, 1);
    idle(3);

    // Reset at the 10th multiply iteration discards the operation
    issue(OP_MUL, 32'h0000_1234, 32'h0000_5678, 32'h0, 0);
    idle(9);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midmul_rst_busy", 32'(bus.busy), 32'h0);
    chk("midmul_rst_done", 32'(bus.done), 32'h0);
    chk("midmul_rst_result", bus.result, 32'h0);
    chk("midmul_rst_zero", 32'(bus.zero), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    idle(40);
    chk("midmul_no_done_result", bus.result, 32'h0);
    issue(OP_MUL, 32'd3, 32'd4, 32'd12, 1);
    idle(40);

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
